// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and constants for the register file dump reader.
//   dump_state_e : FSM states of the dump walker.
//   NUM_REGS     : number of registers walked at the default index width.
//   dump_beat_t  : one (index, value, last) beat at the default widths.
package regfile_dump_reader_pkg;

  localparam int unsigned DefAddrWidth = 5;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned NUM_REGS     = 2 ** DefAddrWidth;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } dump_state_e;

  typedef struct packed {
    logic [DefAddrWidth-1:0] idx;
    logic [DefDataWidth-1:0] data;
    logic                    last;
  } dump_beat_t;

endpackage

// File: rtl/regfile_dump_outreg.sv
// Valid/ready output register for the dump stream, including the capture-data mux.
//   load_i      : capture a new beat this edge (caller guarantees the slot is free).
//   clear_i     : final beat handshaked; drop valid and last.
//   load_idx_i  : index being captured; load_last_i marks the final index.
//   rf_*_i      : read data for load_idx_i plus the snooped write port.
//   valid_o/idx_o/data_o/last_o : registered beat, held stable while not accepted.
module regfile_dump_outreg #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [ADDR_WIDTH-1:0] load_idx_i,
  input  logic                  load_last_i,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  input  logic                  rf_wen_i,
  input  logic [ADDR_WIDTH-1:0] rf_waddr_i,
  input  logic [DATA_WIDTH-1:0] rf_wdata_i,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] idx_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o
);

  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] cap_data;

  // x0 is hardwired zero; a write landing on the captured register this edge
  // wins over the stale read so the beat shows the post-edge value.
  always_comb begin
    if (load_idx_i == '0) begin
      cap_data = '0;
    end else if (rf_wen_i && (rf_waddr_i == load_idx_i)) begin
      cap_data = rf_wdata_i;
    end else begin
      cap_data = rf_rdata_i;
    end
  end

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      idx_d   = load_idx_i;
      data_d  = cap_data;
      last_d  = load_last_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign idx_o   = idx_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks every architectural register through one read port and streams
// (index, value) beats over valid/ready, snooping the write port so writes
// landing at a register's capture edge are reflected.
//   start           : begin a dump (ignored while busy).
//   busy/done       : dump in progress / one-cycle completion pulse.
//   rf_raddr/rf_rdata : shared register file read port (combinational data).
//   rf_wen/rf_waddr/rf_wdata : snooped register file write port.
//   out_*           : beat stream; out_last marks the highest index.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  input  logic                  rf_wen,
  input  logic [ADDR_WIDTH-1:0] rf_waddr,
  input  logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  // Counter carries one extra bit so it never wraps inside a dump.
  localparam logic [ADDR_WIDTH:0] LastCnt = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] CntOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  dump_state_e           state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  load, clear;
  logic                  cnt_is_last;

  assign cnt_is_last = (cnt_q == LastCnt);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load     = 1'b0;
    clear    = 1'b0;
    rf_raddr = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StRun: begin
        rf_raddr = cnt_q[ADDR_WIDTH-1:0];
        // Output slot is free when empty or being drained this edge.
        load = !out_valid || out_ready;
        if (load) begin
          cnt_d = cnt_q + CntOne;
          if (cnt_is_last) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (out_valid && out_ready) begin
          clear   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  regfile_dump_outreg #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_outreg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .clear_i    (clear),
    .load_idx_i (cnt_q[ADDR_WIDTH-1:0]),
    .load_last_i(cnt_is_last),
    .rf_rdata_i (rf_rdata),
    .rf_wen_i   (rf_wen),
    .rf_waddr_i (rf_waddr),
    .rf_wdata_i (rf_wdata),
    .valid_o    (out_valid),
    .idx_o      (out_idx),
    .data_o     (out_data),
    .last_o     (out_last)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule
